box_motion_controller: RTL
==========================

# box_motion_controller

Sequencing controller for the box drawer. It consumes PS/2 set-2 scan-code bytes, tracks the held state of the four arrow keys, and steps the box position once per video frame, clamping it to the screen. It also handles size grow/shrink and colour-cycle keys, and presents registered `boxX`, `boxY`, `boxSize` and `red`/`green`/`blue` directly to the drawer's position, size and colour inputs.

## Interface
- `RES_WIDTH`, 640: horizontal resolution, in pixels.
- `RES_HEIGHT`, 480: vertical resolution, in pixels.
- `STEP`, 4: pixels moved per frame tick per axis.
- `INIT_SIZE`, 40: box size after reset.
- `MIN_SIZE`, 8 / `MAX_SIZE`, 200: size limits.
- `SIZE_STEP`, 8: size change per grow/shrink key press.
- `clock` in 1: single system/pixel clock; everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_code` in 8: byte from the PS/2 receiver.
- `scan_valid` in 1: one-cycle strobe; `scan_code` is valid in this cycle.
- `frame_tick` in 1: one-cycle pulse per frame, at the start of vertical blanking.
- `boxX`, `boxY` out 10: box top-left corner, in pixels.
- `boxSize` out 10: box edge length.
- `red`, `green`, `blue` out 4 each: box colour.

## Operation
- Decoder FSM states:
  - IDLE: `E0` goes to EXT; `F0` goes to BRK; any other byte is a plain make, then stay in IDLE.
  - EXT: `F0` goes to EXT_BRK; any other byte is an extended make, then go to IDLE.
  - BRK: any byte is a plain break, then go to IDLE.
  - EXT_BRK: any byte is an extended break, then go to IDLE.
  - Prefix bytes received in BRK or EXT_BRK are consumed as codes, then the FSM goes to IDLE.
  - The FSM advances only on cycles with `scan_valid`=1.
- Arrow keys are extended codes: up `75`, down `72`, left `6B`, right `74`.
  - An extended make sets the matching held bit.
  - An extended break clears it.
  - Other extended codes are ignored.
- Plain make codes (plain breaks are ignored):
  - `55` ('='): size = min(size+`SIZE_STEP`, `MAX_SIZE`).
  - `4E` ('-'): size = max(size−`SIZE_STEP`, `MIN_SIZE`).
  - `29` (space): colour index 1..7 increments; 7 wraps to 1.
  - Auto-repeat makes re-apply the action.
- Colour mapping:
  - `red` = idx[2] ? `F` : `0`.
  - `green` = idx[1] ? `F` : `0`.
  - `blue` = idx[0] ? `F` : `0`.
  - Index 0 never occurs.
- Motion on `frame_tick`, computed per axis:
  - Left only: x = (x < `STEP`) ? 0 : x−`STEP`.
  - Right only: x = min(x+`STEP`, `RES_WIDTH`−size).
  - Both or neither held: no move.
  - The Y axis is identical, using up/down and `RES_HEIGHT`.
  - Then x = min(x, `RES_WIDTH`−size) and y = min(y, `RES_HEIGHT`−size). This re-clamps the position after a size grow.
- Arithmetic is done in 11 bits, so there is no wrap-around.
- Size growth does not move the box until the next tick. Overhang past the screen edge for under one frame is allowed, because the drawer clips to the resolution.

## Timing
- Reset values:
  - FSM in IDLE; held bits 0; colour index 7 (`F`,`F`,`F`).
  - `boxSize`=`INIT_SIZE`.
  - `boxX`=(`RES_WIDTH`−`INIT_SIZE`)/2 = 300.
  - `boxY`=(`RES_HEIGHT`−`INIT_SIZE`)/2 = 220.
- Asserting `reset_n` low mid-frame or mid-sequence immediately forces the reset values.
- Held bits, size and colour update on the edge after the byte's `scan_valid`; latency is 1 cycle.
- Position updates on the edge after `frame_tick`; latency is 1 cycle. All outputs are registered.
- Simultaneous `scan_valid` and `frame_tick`:
  - Motion uses the held bits and size from before that cycle's byte.
  - The byte's effect is visible at the next tick.
- No backpressure: every `scan_valid` byte is accepted. Consecutive-cycle strobes are legal.

## Test plan
- Reset, then idle for 10 ticks -> `boxX`=300, `boxY`=220, `boxSize`=40, `red`/`green`/`blue`=`F`; no motion.
- `E0 74`, then 3 ticks, then `E0 F0 74`, then 2 ticks -> `boxX`=312 after the 3rd tick and stays 312.
- Hold left (`E0 6B`) for 80 ticks -> `boxX` reaches 0 at tick 75 and stays 0. Hold down for 100 ticks -> `boxY`=440.
- Left and right both held for 5 ticks -> `boxX` unchanged. Release right -> moves 4 per tick.
- `55` ×25 -> `boxSize` saturates at 200. `4E` ×30 -> 8. `29` ×2 -> index 7→1→2 (`0`,`F`,`0`).
- Box at x=600 with size 40, send `55`, then tick -> `boxSize`=48 and `boxX`=592.
- `E0 75` with its `75` byte coincident with `frame_tick` -> no move on that tick; `boxY` −4 on the next tick.
- Pull `reset_n` low between `E0` and `75` -> outputs return to reset values. A subsequent bare `75` is ignored.

Source files
------------

// File: rtl/box_motion_controller.sv
// rtl/box_motion_controller.sv - PS/2 scan-code driven box position, size and colour controller
// Decodes set-2 make/break sequences and steps the box once per frame tick.
module box_motion_controller #(
  parameter int RES_WIDTH  = 640,
  parameter int RES_HEIGHT = 480,
  parameter int STEP       = 4,
  parameter int INIT_SIZE  = 40,
  parameter int MIN_SIZE   = 8,
  parameter int MAX_SIZE   = 200,
  parameter int SIZE_STEP  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       frame_tick,
  output logic [9:0] boxX,
  output logic [9:0] boxY,
  output logic [9:0] boxSize,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam logic [10:0] W11       = 11'(RES_WIDTH);
  localparam logic [10:0] H11       = 11'(RES_HEIGHT);
  localparam logic [10:0] STEP11    = 11'(STEP);
  localparam logic [10:0] INIT11    = 11'(INIT_SIZE);
  localparam logic [10:0] MIN11     = 11'(MIN_SIZE);
  localparam logic [10:0] MAX11     = 11'(MAX_SIZE);
  localparam logic [10:0] SSTEP11   = 11'(SIZE_STEP);
  localparam logic [10:0] INIT_X    = 11'((RES_WIDTH - INIT_SIZE) / 2);
  localparam logic [10:0] INIT_Y    = 11'((RES_HEIGHT - INIT_SIZE) / 2);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_GROW  = 8'h55;
  localparam logic [7:0] CODE_SHRNK = 8'h4E;
  localparam logic [7:0] CODE_COLOR = 8'h29;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic        plain_make, ext_make, ext_break;
  logic [3:0]  held, held_nxt, key_hit;
  logic [10:0] size_q, size_nxt;
  logic [2:0]  idx_q, idx_nxt;
  logic [10:0] x_q, y_q, x_nxt, y_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    plain_make = 1'b0;
    ext_make   = 1'b0;
    ext_break  = 1'b0;
    if (scan_valid) begin
      unique case (state)
        IDLE: begin
          if (scan_code == CODE_EXT)      state_nxt = EXT;
          else if (scan_code == CODE_BRK) state_nxt = BRK;
          else                            plain_make = 1'b1;
        end
        EXT: begin
          if (scan_code == CODE_BRK) state_nxt = EXT_BRK;
          else begin
            ext_make  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: state_nxt = IDLE;
        EXT_BRK: begin
          ext_break = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // held bit order: {up, down, left, right}
  always_comb begin
    key_hit = {scan_code == CODE_UP, scan_code == CODE_DOWN,
               scan_code == CODE_LEFT, scan_code == CODE_RIGHT};
    held_nxt = held;
    if (ext_make)       held_nxt = held | key_hit;
    else if (ext_break) held_nxt = held & ~key_hit;
  end

  always_comb begin
    size_nxt = size_q;
    idx_nxt  = idx_q;
    if (plain_make) begin
      if (scan_code == CODE_GROW)
        size_nxt = (size_q + SSTEP11 > MAX11) ? MAX11 : size_q + SSTEP11;
      else if (scan_code == CODE_SHRNK)
        size_nxt = (size_q < MIN11 + SSTEP11) ? MIN11 : size_q - SSTEP11;
      else if (scan_code == CODE_COLOR)
        idx_nxt = (idx_q == 3'd7) ? 3'd1 : idx_q + 3'd1;
    end
  end

  function automatic logic [10:0] step_axis(input logic [10:0] pos,
                                            input logic [10:0] lim,
                                            input logic        dec,
                                            input logic        inc);
    logic [10:0] p;
    p = pos;
    if (dec && !inc)      p = (pos < STEP11) ? 11'd0 : pos - STEP11;
    else if (inc && !dec) p = (pos + STEP11 > lim) ? lim : pos + STEP11;
    // final clamp also pulls the box back after a size grow
    if (p > lim) p = lim;
    return p;
  endfunction

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (frame_tick) begin
      x_nxt = step_axis(x_q, W11 - size_q, held[1], held[0]);
      y_nxt = step_axis(y_q, H11 - size_q, held[3], held[2]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held   <= 4'd0;
      size_q <= INIT11;
      idx_q  <= 3'd7;
      x_q    <= INIT_X;
      y_q    <= INIT_Y;
    end else begin
      held   <= held_nxt;
      size_q <= size_nxt;
      idx_q  <= idx_nxt;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
    end
  end

  assign boxX    = x_q[9:0];
  assign boxY    = y_q[9:0];
  assign boxSize = size_q[9:0];
  assign red     = {4{idx_q[2]}};
  assign green   = {4{idx_q[1]}};
  assign blue    = {4{idx_q[0]}};

  logic unused_msb;
  assign unused_msb = x_q[10] ^ y_q[10] ^ size_q[10];

endmodule
